// File: rtl/pong_game_ctrl_if.sv
// Control/status bundle between the Pong game-logic sequencer and its surroundings.
// The master side drives frame tick, buttons and serve; the slave side returns positions and scores.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       p1_up;
    logic       p1_down;
    logic       p2_up;
    logic       p2_down;
    logic       serve;
    logic [8:0] stickp1;
    logic [8:0] stickp2;
    logic [9:0] ballx;
    logic [8:0] bally;
    logic [3:0] scorep1;
    logic [3:0] scorep2;
    logic       game_over;
    logic [1:0] state;

    modport master (
        output frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
        input  stickp1, stickp2, ballx, bally, scorep1, scorep2, game_over, state
    );

    modport slave (
        input  frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
        output stickp1, stickp2, ballx, bally, scorep1, scorep2, game_over, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-logic sequencer: once per frame_tick it moves sticks and ball, resolves
// bounces and goals, keeps score and runs the IDLE/PLAY/POINT/GAMEOVER sequence.
module pong_game_ctrl #(
    parameter int STICKSIZE    = 64,
    parameter int STICKWIDTH   = 8,
    parameter int STICKP1X     = 32,
    parameter int STICKP2X     = 600,
    parameter int BALLSIZE     = 8,
    parameter int STICK_SPEED  = 4,
    parameter int BALL_SPEED   = 2,
    parameter int PAUSE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    pong_game_ctrl_if.slave bus
);
    localparam int STICK_MAX = 479 - STICKSIZE;
    localparam int P1_FACE   = STICKP1X + STICKWIDTH;
    localparam int P2_STOP   = STICKP2X - BALLSIZE;
    localparam int BALL_MAXY = 479 - BALLSIZE;
    localparam int CNT_W     = $clog2(PAUSE_FRAMES + 1);

    localparam logic [8:0]       STICK0   = 9'((480 - STICKSIZE) / 2);
    localparam logic [9:0]       BALL_X0  = 10'((640 - BALLSIZE) / 2);
    localparam logic [8:0]       BALL_Y0  = 9'((480 - BALLSIZE) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_POINT = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t           r_state,  w_state;
    logic [8:0]       r_stick1, w_stick1;
    logic [8:0]       r_stick2, w_stick2;
    logic [9:0]       r_ballx,  w_ballx;
    logic [8:0]       r_bally,  w_bally;
    logic [3:0]       r_score1, w_score1;
    logic [3:0]       r_score2, w_score2;
    logic             r_dx,     w_dx;      // 1 = moving right
    logic             r_dy,     w_dy;      // 1 = moving down
    logic [CNT_W-1:0] r_cnt,    w_cnt;

    logic [10:0] w_bx, w_by, w_s1, w_s2;
    logic        w_ov1, w_ov2, w_hit1, w_hit2, w_goal1, w_goal2;

    function automatic logic [8:0] stick_step(input logic [8:0] pos, input logic up, input logic dn);
        logic [10:0] p;
        p = {2'b00, pos};
        stick_step = pos;
        if (up && !dn) begin
            if (p < 11'(1 + STICK_SPEED)) stick_step = 9'd1;
            else                          stick_step = 9'(p - 11'(STICK_SPEED));
        end else if (dn && !up) begin
            if (p + 11'(STICK_SPEED) > 11'(STICK_MAX)) stick_step = 9'(STICK_MAX);
            else                                        stick_step = 9'(p + 11'(STICK_SPEED));
        end
    endfunction

    function automatic logic [3:0] score_inc(input logic [3:0] s);
        score_inc = (s >= 4'd9) ? 4'd9 : s + 4'd1;
    endfunction

    // Widen everything to 11 bits so sums and differences can never wrap
    assign w_bx = {1'b0, r_ballx};
    assign w_by = {2'b00, r_bally};
    assign w_s1 = {2'b00, r_stick1};
    assign w_s2 = {2'b00, r_stick2};

    assign w_ov1   = (w_by + 11'(BALLSIZE) > w_s1) && (w_by < w_s1 + 11'(STICKSIZE));
    assign w_ov2   = (w_by + 11'(BALLSIZE) > w_s2) && (w_by < w_s2 + 11'(STICKSIZE));
    assign w_hit1  = !r_dx && w_ov1 && (w_bx >= 11'(P1_FACE)) && (w_bx < 11'(P1_FACE + BALL_SPEED));
    assign w_hit2  = r_dx && w_ov2 && (w_bx + 11'(BALLSIZE) <= 11'(STICKP2X))
                     && (w_bx + 11'(BALLSIZE + BALL_SPEED) > 11'(STICKP2X));
    assign w_goal2 = !r_dx && !w_hit1 && (w_bx < 11'(BALL_SPEED));
    assign w_goal1 = r_dx && !w_hit2 && (w_bx + 11'(BALLSIZE + BALL_SPEED) > 11'd640);

    always_comb begin
        w_state  = r_state;
        w_stick1 = r_stick1;
        w_stick2 = r_stick2;
        w_ballx  = r_ballx;
        w_bally  = r_bally;
        w_score1 = r_score1;
        w_score2 = r_score2;
        w_dx     = r_dx;
        w_dy     = r_dy;
        w_cnt    = r_cnt;
        if (bus.frame_tick) begin
            if (r_state != S_OVER) begin
                w_stick1 = stick_step(r_stick1, bus.p1_up, bus.p1_down);
                w_stick2 = stick_step(r_stick2, bus.p2_up, bus.p2_down);
            end
            case (r_state)
                S_IDLE: begin
                    w_ballx = BALL_X0;
                    w_bally = BALL_Y0;
                    if (bus.serve) w_state = S_PLAY;
                end
                S_PLAY: begin
                    // A goal freezes the ball and aims the next serve at the player who conceded
                    if (w_goal1) begin
                        w_score1 = score_inc(r_score1);
                        w_dx     = 1'b1;
                        w_cnt    = '0;
                        w_state  = S_POINT;
                    end else if (w_goal2) begin
                        w_score2 = score_inc(r_score2);
                        w_dx     = 1'b0;
                        w_cnt    = '0;
                        w_state  = S_POINT;
                    end else begin
                        if (w_hit1) begin
                            w_ballx = 10'(P1_FACE);
                            w_dx    = 1'b1;
                        end else if (w_hit2) begin
                            w_ballx = 10'(P2_STOP);
                            w_dx    = 1'b0;
                        end else if (r_dx) begin
                            w_ballx = 10'(w_bx + 11'(BALL_SPEED));
                        end else begin
                            w_ballx = 10'(w_bx - 11'(BALL_SPEED));
                        end
                        if (!r_dy && (w_by < 11'(1 + BALL_SPEED))) begin
                            w_bally = 9'd1;
                            w_dy    = 1'b1;
                        end else if (r_dy && (w_by + 11'(BALLSIZE + BALL_SPEED) > 11'd479)) begin
                            w_bally = 9'(BALL_MAXY);
                            w_dy    = 1'b0;
                        end else if (r_dy) begin
                            w_bally = 9'(w_by + 11'(BALL_SPEED));
                        end else begin
                            w_bally = 9'(w_by - 11'(BALL_SPEED));
                        end
                    end
                end
                S_POINT: begin
                    if (r_cnt == CNT_LAST) begin
                        w_ballx = BALL_X0;
                        w_bally = BALL_Y0;
                        w_dy    = 1'b1;
                        w_cnt   = '0;
                        w_state = ((r_score1 == 4'(WIN_SCORE)) || (r_score2 == 4'(WIN_SCORE))) ? S_OVER : S_IDLE;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_OVER: begin
                    if (bus.serve) begin
                        w_score1 = 4'd0;
                        w_score2 = 4'd0;
                        w_ballx  = BALL_X0;
                        w_bally  = BALL_Y0;
                        w_dx     = 1'b1;
                        w_dy     = 1'b1;
                        w_state  = S_IDLE;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_stick1 <= STICK0;
            r_stick2 <= STICK0;
            r_ballx  <= BALL_X0;
            r_bally  <= BALL_Y0;
            r_score1 <= 4'd0;
            r_score2 <= 4'd0;
            r_dx     <= 1'b1;
            r_dy     <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state;
            r_stick1 <= w_stick1;
            r_stick2 <= w_stick2;
            r_ballx  <= w_ballx;
            r_bally  <= w_bally;
            r_score1 <= w_score1;
            r_score2 <= w_score2;
            r_dx     <= w_dx;
            r_dy     <= w_dy;
            r_cnt    <= w_cnt;
        end
    end

    assign bus.stickp1   = r_stick1;
    assign bus.stickp2   = r_stick2;
    assign bus.ballx     = r_ballx;
    assign bus.bally     = r_bally;
    assign bus.scorep1   = r_score1;
    assign bus.scorep2   = r_score2;
    assign bus.game_over = (r_state == S_OVER);
    assign bus.state     = r_state;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a frame-level game model predicts every output
// after each frame_tick; directed constant checks pin the key corner cases.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pong_game_ctrl_if bus ();
    pong_game_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int s1, s2, bx, by, sc1, sc2, go, st, evt;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Model state: dx 1 = right, dy 1 = down
    int m_s1, m_s2, m_bx, m_by, m_sc1, m_sc2, m_st, m_dx, m_dy, m_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 208; m_s2 = 208; m_bx = 316; m_by = 236;
        m_sc1 = 0; m_sc2 = 0; m_st = 0; m_dx = 1; m_dy = 1; m_cnt = 0;
    endtask

    function automatic int stick_next(input int s, input bit up, input bit dn);
        if (up && !dn) return (s - 4 < 1) ? 1 : s - 4;
        if (dn && !up) return (s + 4 > 415) ? 415 : s + 4;
        return s;
    endfunction

    task automatic model_step();
        exp_t e;
        int n1, n2, goal, evt;
        n1 = m_s1; n2 = m_s2; goal = 0; evt = 0;
        if (m_st != 3) begin
            n1 = stick_next(m_s1, bus.p1_up, bus.p1_down);
            n2 = stick_next(m_s2, bus.p2_up, bus.p2_down);
        end
        case (m_st)
            0: if (bus.serve) m_st = 1;
            1: begin
                if (m_dx == 0) begin
                    if (m_bx >= 40 && m_bx - 2 < 40 && m_by + 8 > m_s1 && m_by < m_s1 + 64) begin
                        m_bx = 40; m_dx = 1; evt = 1;
                    end else if (m_bx < 2) goal = 2;
                    else m_bx = m_bx - 2;
                end else begin
                    if (m_bx + 8 <= 600 && m_bx + 10 > 600 && m_by + 8 > m_s2 && m_by < m_s2 + 64) begin
                        m_bx = 592; m_dx = 0; evt = 2;
                    end else if (m_bx + 10 > 640) goal = 1;
                    else m_bx = m_bx + 2;
                end
                if (goal == 1) begin
                    m_sc1 = (m_sc1 >= 9) ? 9 : m_sc1 + 1; m_dx = 1; m_cnt = 0; m_st = 2; evt = 3;
                end else if (goal == 2) begin
                    m_sc2 = (m_sc2 >= 9) ? 9 : m_sc2 + 1; m_dx = 0; m_cnt = 0; m_st = 2; evt = 3;
                end else if (m_dy == 0) begin
                    if (m_by < 3) begin m_by = 1; m_dy = 1; end
                    else m_by = m_by - 2;
                end else begin
                    if (m_by + 10 > 479) begin m_by = 471; m_dy = 0; end
                    else m_by = m_by + 2;
                end
            end
            2: begin
                if (m_cnt == 59) begin
                    m_bx = 316; m_by = 236; m_dy = 1;
                    m_st = (m_sc1 == 9 || m_sc2 == 9) ? 3 : 0;
                end else m_cnt++;
            end
            default: if (bus.serve) begin
                m_sc1 = 0; m_sc2 = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_st = 0;
            end
        endcase
        m_s1 = n1; m_s2 = n2;
        e.s1 = m_s1; e.s2 = m_s2; e.bx = m_bx; e.by = m_by; e.sc1 = m_sc1; e.sc2 = m_sc2;
        e.go = (m_st == 3) ? 1 : 0; e.st = m_st; e.evt = evt;
        q.push_back(e);
    endtask

    function automatic logic [47:0] pack_dut();
        return {bus.stickp1, bus.stickp2, bus.ballx, bus.bally, bus.scorep1, bus.scorep2, bus.game_over, bus.state};
    endfunction

    function automatic logic [47:0] pack_exp(input exp_t e);
        return {9'(e.s1), 9'(e.s2), 10'(e.bx), 9'(e.by), 4'(e.sc1), 4'(e.sc2), 1'(e.go), 2'(e.st)};
    endfunction

    task automatic check_reset(input string tag);
        check_val({tag, "_stickp1"}, bus.stickp1, 208);
        check_val({tag, "_stickp2"}, bus.stickp2, 208);
        check_val({tag, "_ballx"}, bus.ballx, 316);
        check_val({tag, "_bally"}, bus.bally, 236);
        check_val({tag, "_scorep1"}, bus.scorep1, 0);
        check_val({tag, "_scorep2"}, bus.scorep2, 0);
        check_val({tag, "_game_over"}, bus.game_over, 0);
        check_val({tag, "_state"}, bus.state, 0);
    endtask

    // One frame: tick at a negedge, compare one cycle later; b2b keeps frame_tick high for the next frame
    task automatic frame(input bit b2b);
        exp_t e;
        bus.frame_tick = 1'b1;
        model_step();
        @(negedge clk);
        check_val("sb_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check_val("stickp1", bus.stickp1, e.s1);
            check_val("stickp2", bus.stickp2, e.s2);
            check_val("ballx", bus.ballx, e.bx);
            check_val("bally", bus.bally, e.by);
            check_val("scorep1", bus.scorep1, e.sc1);
            check_val("scorep2", bus.scorep2, e.sc2);
            check_val("game_over", bus.game_over, e.go);
            check_val("state", bus.state, e.st);
            if (e.evt == 1) check_val("p1_bounce_x", bus.ballx, 40);
            if (e.evt == 2) check_val("p2_bounce_x", bus.ballx, 592);
            if (!b2b) begin
                bus.frame_tick = 1'b0;
                @(negedge clk);
                check_val("hold_between_ticks", pack_dut(), pack_exp(e));
            end
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0);
    endtask

    task automatic track_p2();
        int tgt;
        tgt = m_by + 4 - 32;
        bus.p2_down = (m_s2 < tgt - 2);
        bus.p2_up   = (m_s2 > tgt + 2);
    endtask

    task automatic track_p1();
        int tgt;
        tgt = m_by + 4 - 32;
        bus.p1_down = (m_s1 < tgt - 2);
        bus.p1_up   = (m_s1 > tgt + 2);
    endtask

    initial begin
        int s1_frozen, s2_frozen;
        bus.frame_tick = 0; bus.p1_up = 0; bus.p1_down = 0;
        bus.p2_up = 0; bus.p2_down = 0; bus.serve = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("no_tick");

        frames(5);
        check_val("idle_state", bus.state, 0);
        check_val("idle_ballx", bus.ballx, 316);

        bus.p1_up = 1; bus.p1_down = 1;
        frames(5);
        check_val("both_held", bus.stickp1, 208);
        bus.p1_down = 0;
        frames(60);
        check_val("p1_sat_top", bus.stickp1, 1);
        bus.p1_up = 0; bus.p2_down = 1;
        frames(60);
        check_val("p2_sat_bottom", bus.stickp2, 415);
        bus.p2_down = 0; bus.p2_up = 1;
        frames(120);
        bus.p2_up = 0;

        // Serve: ball holds on the serve tick, then runs right into P1's goal
        bus.serve = 1;
        frame(1'b0);
        check_val("serve_state", bus.state, 1);
        check_val("serve_ballx", bus.ballx, 316);
        bus.serve = 0;
        frame(1'b0);
        check_val("first_move_x", bus.ballx, 318);
        for (int i = 0; i < 400 && m_st != 2; i++) frame(1'b0);
        check_val("goal_p1_score", bus.scorep1, 1);
        check_val("goal_p1_state", bus.state, 2);
        check_val("goal_p1_ballx", bus.ballx, 632);

        bus.serve = 1;
        frames(59);
        check_val("pause_still_point", bus.state, 2);
        bus.serve = 0;
        frame(1'b0);
        check_val("pause_end_state", bus.state, 0);
        check_val("pause_end_ballx", bus.ballx, 316);
        check_val("pause_end_bally", bus.bally, 236);
        bus.serve = 1;
        frame(1'b0);
        bus.serve = 0;
        frame(1'b0);
        check_val("reserve_dir_x", bus.ballx, 318);

        // Rally with both sticks tracking, including back-to-back ticks
        for (int i = 0; i < 900; i++) begin
            track_p1();
            track_p2();
            frame((i % 7 == 3) && (i < 899));
        end

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("async_rst");
        @(negedge clk);
        check_reset("async_rst_hold");
        rst_n = 1'b1;
        model_reset();
        bus.p1_up = 0; bus.p1_down = 0; bus.p2_up = 0; bus.p2_down = 0;

        // P2 defends, P1 dodges: P2 wins nine points
        for (int i = 0; i < 20000 && m_st != 3; i++) begin
            track_p2();
            bus.p1_down = (m_by < 240);
            bus.p1_up   = (m_by >= 240);
            bus.serve   = (m_st == 0);
            frame(1'b0);
        end
        bus.serve = 0;
        check_val("win_scorep2", bus.scorep2, 9);
        check_val("win_scorep1", bus.scorep1, 0);
        check_val("win_state", bus.state, 3);
        check_val("win_game_over", bus.game_over, 1);

        s1_frozen = m_s1; s2_frozen = m_s2;
        bus.p1_up = 1; bus.p1_down = 0; bus.p2_up = 0; bus.p2_down = 1;
        frames(5);
        check_val("frozen_p1", bus.stickp1, s1_frozen);
        check_val("frozen_p2", bus.stickp2, s2_frozen);
        bus.p1_up = 0; bus.p2_down = 0;

        bus.serve = 1;
        frame(1'b0);
        bus.serve = 0;
        check_val("restart_scorep1", bus.scorep1, 0);
        check_val("restart_scorep2", bus.scorep2, 0);
        check_val("restart_state", bus.state, 0);
        check_val("restart_game_over", bus.game_over, 0);
        check_val("restart_ballx", bus.ballx, 316);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
